// File: rtl/flit_pkg.sv
// Flit encoding and link-arbiter state shared by the NoC link and router arbiters.
package flit_pkg;

    localparam int DEF_FLIT_DATA_WIDTH = 32;
    localparam int DEF_FLIT_TYPE_WIDTH = 2;

    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } link_state_e;

    function automatic logic opens_packet(input logic [1:0] flit_type);
        return (flit_type != FLIT_BODY) && (flit_type != FLIT_TAIL);
    endfunction

    function automatic logic closes_packet(input logic [1:0] flit_type);
        return (flit_type == FLIT_TAIL) || (flit_type == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/flit_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/flit_link_arbiter.sv
// Wormhole round-robin arbiter sharing one flit link between N_REQ sources,
// feeding the link through a one-entry registered output stage.
module flit_link_arbiter
    import flit_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int FLIT_DATA_WIDTH = DEF_FLIT_DATA_WIDTH,
    parameter int FLIT_TYPE_WIDTH = DEF_FLIT_TYPE_WIDTH,
    localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ*FLIT_WIDTH-1:0] in_flit,
    input  logic [N_REQ-1:0]            in_valid,
    output logic [N_REQ-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]       out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_REQ-1:0]            grant,
    output logic                        proto_err
);

    localparam int PTR_W = $clog2(N_REQ);

    link_state_e           state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  first_q, first_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic                  out_valid_q, out_valid_d;
    logic                  proto_err_q, proto_err_d;

    logic [N_REQ-1:0]           head_req;
    logic [N_REQ-1:0]           bad_req;
    logic [N_REQ-1:0]           pick_grant;
    logic [PTR_W-1:0]           pick_idx;
    logic                       pick_any;
    logic                       out_free;
    logic                       accept;
    logic [FLIT_WIDTH-1:0]      acc_flit;
    logic [FLIT_TYPE_WIDTH-1:0] acc_type;

    // Classify every presented flit: packet openers compete, stray BODY/TAIL are errors.
    always_comb begin
        logic [FLIT_TYPE_WIDTH-1:0] typ;
        head_req = '0;
        bad_req  = '0;
        typ      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            typ = in_flit[i*FLIT_WIDTH + FLIT_DATA_WIDTH +: FLIT_TYPE_WIDTH];
            if (in_valid[i]) begin
                if (opens_packet(typ)) head_req[i] = 1'b1;
                else                   bad_req[i]  = 1'b1;
            end
        end
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (head_req),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            first_q     <= 1'b0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            first_q     <= first_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        first_d     = first_q;
        proto_err_d = 1'b0;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                proto_err_d = |bad_req;
                if (pick_any) begin
                    state_d = LOCKED;
                    grant_d = pick_grant;
                    owner_d = pick_idx;
                    first_d = 1'b1;
                end
            end
            LOCKED: begin
                if (accept) begin
                    first_d = 1'b0;
                    // A repeated HEAD is flagged but still forwarded under the same lock.
                    proto_err_d = (acc_type == FLIT_HEAD) && !first_q;
                    if (closes_packet(acc_type)) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_flit_d  = acc_flit;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_free = ~out_valid_q | out_ready;
        in_ready = (state_q == LOCKED && out_free) ? grant_q : '0;
        accept   = |(in_valid & in_ready);
        acc_flit = in_flit[owner_q*FLIT_WIDTH +: FLIT_WIDTH];
        acc_type = acc_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
    end

    assign out_flit  = out_flit_q;
    assign out_valid = out_valid_q;
    assign grant     = grant_q;
    assign proto_err = proto_err_q;

endmodule

// File: doc/flit_link_arbiter.md
Name: flit_link_arbiter

Overview:
- Shares one NoC output link between N_REQ flit sources, e.g. several packetizers feeding one router input port.
- Arbitrates per packet using round-robin priority.
- Locks the grant to the winner from its head flit until its tail flit (wormhole), so flits of different packets never interleave.
- Drives the link through a one-entry registered output stage.

Parameters:
- N_REQ, 4, number of requesting flit sources (2..16)
- FLIT_DATA_WIDTH, 32, flit payload bits
- FLIT_TYPE_WIDTH, 2, flit type bits; always the MSBs of a flit
- FLIT_WIDTH, FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH, derived, total flit bits

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- in_flit  in  N_REQ*FLIT_WIDTH  source i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH]
- in_valid  in  N_REQ  source i presents a flit
- in_ready  out  N_REQ  source i flit accepted this cycle when in_valid[i]&in_ready[i]
- out_flit  out  FLIT_WIDTH  link flit, registered
- out_valid  out  1  link flit valid, registered
- out_ready  in  1  downstream accepts out_flit this cycle
- grant  out  N_REQ  one-hot current link owner; all zero when idle
- proto_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Flit type encoding (MSBs):
  - 2'b01 HEAD
  - 2'b00 BODY
  - 2'b10 TAIL
  - 2'b11 SINGLE (head and tail in one flit)
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, rr_ptr=0
  - out_valid=0, out_flit=0, proto_err=0
  - in_ready is combinationally 0
- Output stage:
  - out_free = ~out_valid | out_ready
  - in_ready[i] = (state==LOCKED) & grant[i] & out_free
  - An accepted flit loads out_flit and sets out_valid on the next edge.
  - If out_valid=1 and out_ready=1 with no accept, out_valid clears.
  - While out_valid=1 and out_ready=0, out_flit/out_valid hold stable.
  - Throughput is one flit per cycle while the owner streams and out_ready=1.
- IDLE state:
  - Eligible set is sources with in_valid=1 and type HEAD or SINGLE.
  - Winner is the first eligible index at or after rr_ptr, searching upward and wrapping modulo N_REQ.
  - If the eligible set is non-empty: grant<=onehot(winner) and state<=LOCKED on the next edge. There is no accept in the IDLE cycle.
  - Any source with in_valid=1 presenting BODY/TAIL: proto_err pulses, the flit is not accepted, and the source is not granted.
- LOCKED state:
  - Only the granted source may transfer.
  - On accepting a TAIL or SINGLE flit: state<=IDLE, grant<=0, rr_ptr<=(owner+1) mod N_REQ.
  - On accepting a HEAD from the owner while LOCKED (except the first flit of the lock): proto_err pulses, the flit is forwarded anyway, and the lock is kept.
  - Owner dropping in_valid mid-packet: the lock is held indefinitely and no timeout exists.
- Latency:
  - Head presented in IDLE with link free: grant at cycle +1, accept at +1, out_valid at +2.
  - One IDLE bubble cycle always follows each tail.
- Simultaneous events:
  - Several heads in the same IDLE cycle resolve by rr_ptr.
  - Requests from non-owners during LOCKED are ignored, with in_ready=0.
- Reset mid-packet: immediate return to reset values. Any in-flight out_flit is discarded.

Decomposition:
- Shared package flit_pkg:
  - FLIT_DATA_WIDTH/FLIT_TYPE_WIDTH defaults
  - Type localparams FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE
  - State encoding IDLE/LOCKED
- One sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: onehot grant, binary index, any.
  - Reused by later router arbiters.

Test Plan:
1. Reset then single source 0 sends HEAD 0x1_00000001, BODY 0x0_00000002, TAIL 0x2_00000003 with out_ready=1 -> grant=0001 one cycle after in_valid; out_flit shows the three flits on consecutive cycles starting 2 cycles after in_valid; grant returns to 0 after the tail.
2. Sources 0 and 2 present HEADs simultaneously with rr_ptr=0 -> source 0 packet completes first; after one IDLE bubble grant=0100; rr_ptr ends at 3.
3. Interleave check: source 1 packet HEAD,BODY,BODY,TAIL while source 3 holds a HEAD valid -> no source 3 flit appears on out_flit until source 1 TAIL has been emitted.
4. Backpressure: out_ready=0 for 3 cycles mid-packet -> out_flit/out_valid stable throughout; in_ready[owner]=0; no flit lost or duplicated after release.
5. Protocol error: source 2 presents BODY 0x0_0000AAAA in IDLE -> proto_err=1 for one cycle; grant stays 0; nothing transferred. SINGLE 0x3_00000005 then yields a 1-flit packet and returns to IDLE.
6. Assert rst=0 asynchronously mid-packet (between clock edges) -> out_valid, grant and in_ready drop immediately. After release, a fresh HEAD from source 0 wins with rr_ptr=0.
